// File: rtl/chroma_mode_decide8x8.sv
// Intra chroma 8x8 mode decision: per-mode SAD over V/H/DC residuals, picks minimum (ties DC>H>V).
// Latency: start accepted at T0, rows summed T1..T8, compare at T9, done pulses the cycle after T9.
// No backpressure: one block every 11 cycles; start outside IDLE is dropped, inputs must stay stable.
module chroma_mode_decide8x8 #(
  parameter int SADW = 14
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [63:0][7:0]      vres,
  input  logic [63:0][7:0]      hres,
  input  logic [63:0][7:0]      dcres,
  output logic                  busy,
  output logic                  done,
  output logic [1:0]            mode,
  output logic [SADW-1:0]       sad,
  output logic [63:0][7:0]      bestres
);

  typedef enum logic [1:0] {IDLE, ACC, CMP, DONE} state_t;

  localparam logic [1:0] MODE_DC = 2'd0;
  localparam logic [1:0] MODE_H  = 2'd1;
  localparam logic [1:0] MODE_V  = 2'd2;

  state_t            state_q, state_d;
  logic [2:0]        row_q, row_d;
  logic [SADW-1:0]   sad_v_q, sad_v_d;
  logic [SADW-1:0]   sad_h_q, sad_h_d;
  logic [SADW-1:0]   sad_dc_q, sad_dc_d;
  logic [1:0]        mode_q, mode_d;
  logic [SADW-1:0]   sad_q, sad_d;
  logic [63:0][7:0]  bestres_q, bestres_d;

  logic [10:0]       rs_v, rs_h, rs_dc;

  // Magnitude of a signed byte, widened to 9 bits first so -128 becomes +128.
  function automatic logic [8:0] abs9(input logic [7:0] b);
    logic [8:0] x;
    x = {b[7], b};
    return x[8] ? (~x + 9'd1) : x;
  endfunction

  // Sum of magnitudes of the 8 residuals in one raster row (max 8*128 = 1024).
  function automatic logic [10:0] row_sad(input logic [63:0][7:0] r, input logic [2:0] row);
    logic [10:0] s;
    logic [5:0]  idx;
    s = '0;
    for (int k = 0; k < 8; k++) begin
      idx = {row, 3'(k)};
      s   = s + {2'b00, abs9(r[idx])};
    end
    return s;
  endfunction

  assign rs_v  = row_sad(vres,  row_q);
  assign rs_h  = row_sad(hres,  row_q);
  assign rs_dc = row_sad(dcres, row_q);

  // Next-state, accumulation and result capture; everything holds by default.
  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    sad_v_d   = sad_v_q;
    sad_h_d   = sad_h_q;
    sad_dc_d  = sad_dc_q;
    mode_d    = mode_q;
    sad_d     = sad_q;
    bestres_d = bestres_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = ACC;
          row_d    = 3'd0;
          sad_v_d  = '0;
          sad_h_d  = '0;
          sad_dc_d = '0;
        end
      end
      ACC: begin
        sad_v_d  = sad_v_q  + {{(SADW-11){1'b0}}, rs_v};
        sad_h_d  = sad_h_q  + {{(SADW-11){1'b0}}, rs_h};
        sad_dc_d = sad_dc_q + {{(SADW-11){1'b0}}, rs_dc};
        row_d    = row_q + 3'd1;
        if (row_q == 3'd7) state_d = CMP;
      end
      CMP: begin
        // Non-strict compares give the lower mode number the win on ties.
        if ((sad_dc_q <= sad_h_q) && (sad_dc_q <= sad_v_q)) begin
          mode_d    = MODE_DC;
          sad_d     = sad_dc_q;
          bestres_d = dcres;
        end else if (sad_h_q <= sad_v_q) begin
          mode_d    = MODE_H;
          sad_d     = sad_h_q;
          bestres_d = hres;
        end else begin
          mode_d    = MODE_V;
          sad_d     = sad_v_q;
          bestres_d = vres;
        end
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and result registers; synchronous active-low reset discards any partial block.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      row_q     <= 3'd0;
      sad_v_q   <= '0;
      sad_h_q   <= '0;
      sad_dc_q  <= '0;
      mode_q    <= 2'd0;
      sad_q     <= '0;
      bestres_q <= '0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      sad_v_q   <= sad_v_d;
      sad_h_q   <= sad_h_d;
      sad_dc_q  <= sad_dc_d;
      mode_q    <= mode_d;
      sad_q     <= sad_d;
      bestres_q <= bestres_d;
    end
  end

  assign busy    = (state_q == ACC) || (state_q == CMP);
  assign done    = (state_q == DONE);
  assign mode    = mode_q;
  assign sad     = sad_q;
  assign bestres = bestres_q;

endmodule

// File: tb/tb_chroma_mode_decide8x8.sv
// Randomized and directed bench for chroma_mode_decide8x8 with a queue-based scoreboard.
// Expected results come from a plain-arithmetic model; a negedge monitor checks busy/done/outputs.
// Every wait on the DUT is bounded; the bench always reaches its summary line.
module tb_chroma_mode_decide8x8;

  localparam int SADW = 14;

  typedef logic [63:0][7:0] vec_t;
  typedef struct {
    logic [1:0] mode;
    int         sad;
    vec_t       res;
  } exp_t;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            start = 1'b0;
  vec_t            vres = '0, hres = '0, dcres = '0;
  logic            busy, done;
  logic [1:0]      mode;
  logic [SADW-1:0] sad;
  vec_t            bestres;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  exp_t exp_q[$];
  exp_t last;
  bit   have_last = 1'b0;
  bit   mon_en = 1'b0;
  bit   blk_active = 1'b0;
  int   blk_t0 = 0;
  int   el;
  bit   exp_busy, exp_done;

  chroma_mode_decide8x8 #(.SADW(SADW)) dut (
    .clk(clk), .reset(reset), .start(start),
    .vres(vres), .hres(hres), .dcres(dcres),
    .busy(busy), .done(done), .mode(mode), .sad(sad), .bestres(bestres)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input bit ok, input logic [511:0] act, input logic [511:0] req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  function automatic int sad_of(input vec_t a);
    int s = 0;
    for (int i = 0; i < 64; i++) begin
      int x;
      x = $signed(a[i]);
      s += (x < 0) ? -x : x;
    end
    return s;
  endfunction

  // Reference: SAD per mode, minimum with lower mode number winning ties.
  function automatic exp_t model(input vec_t v, input vec_t h, input vec_t d);
    exp_t e;
    int s[3];
    int b;
    s[0] = sad_of(d);
    s[1] = sad_of(h);
    s[2] = sad_of(v);
    b = 0;
    if (s[1] < s[b]) b = 1;
    if (s[2] < s[b]) b = 2;
    e.mode = 2'(b);
    e.sad  = s[b];
    e.res  = (b == 0) ? d : ((b == 1) ? h : v);
    return e;
  endfunction

  function automatic vec_t fill(input logic [7:0] b);
    vec_t x;
    for (int i = 0; i < 64; i++) x[i] = b;
    return x;
  endfunction

  function automatic vec_t rnd_vec(input int maxmag);
    vec_t x;
    for (int i = 0; i < 64; i++) x[i] = 8'($signed($urandom_range(0, 2 * maxmag)) - maxmag);
    return x;
  endfunction

  function automatic exp_t zero_exp();
    exp_t e;
    e.mode = 2'd0;
    e.sad  = 0;
    e.res  = '0;
    return e;
  endfunction

  // Monitor: busy/done profile from the accepted start, outputs against the scoreboard.
  always @(negedge clk) begin
    if (mon_en) begin
      el       = cyc - blk_t0;
      exp_busy = blk_active && (el >= 0) && (el <= 8);
      exp_done = blk_active && (el == 9);
      chk("busy", busy == exp_busy, 512'(busy), 512'(exp_busy));
      chk("done", done == exp_done, 512'(done), 512'(exp_done));
      if (exp_done) begin
        blk_active = 1'b0;
        if (exp_q.size() > 0) begin
          last      = exp_q.pop_front();
          have_last = 1'b1;
        end
      end
      if (have_last) begin
        chk("mode", mode == last.mode, 512'(mode), 512'(last.mode));
        chk("sad", int'(sad) == last.sad, 512'(sad), 512'(last.sad));
        chk("bestres", bestres == last.res, 512'(bestres), 512'(last.res));
      end
    end
  end

  // Drive one block; start is sampled at the next edge (T0).
  task automatic issue(input vec_t v, input vec_t h, input vec_t d);
    vres  = v;
    hres  = h;
    dcres = d;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    exp_q.push_back(model(v, h, d));
    blk_t0     = cyc;
    blk_active = 1'b1;
  endtask

  task automatic wait_done();
    int n = 0;
    while (blk_active && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (blk_active) begin
      failures++;
      $display("FAIL timeout: no done within %0d cycles of start at cycle %0d", n, blk_t0);
      blk_active = 1'b0;
      exp_q.delete();
    end
  endtask

  vec_t a, b, c, alt;

  initial begin
    // 1: reset held low with start high
    a = rnd_vec(128);
    vres = a; hres = a; dcres = a;
    reset = 1'b0;
    start = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    start = 1'b0;
    chk("rst_busy", busy == 1'b0, 512'(busy), 512'(0));
    chk("rst_done", done == 1'b0, 512'(done), 512'(0));
    chk("rst_mode", mode == 2'd0, 512'(mode), 512'(0));
    chk("rst_sad", sad == '0, 512'(sad), 512'(0));
    chk("rst_bestres", bestres == '0, 512'(bestres), 512'(0));
    last      = zero_exp();
    have_last = 1'b1;
    reset     = 1'b1;
    mon_en    = 1'b1;
    @(posedge clk);
    #1;

    // 2: distinct minimum, vertical wins
    issue(fill(8'd1), fill(8'd2), fill(8'd3));
    wait_done();

    // 3: H and DC tie at 64, DC wins
    for (int i = 0; i < 64; i++) alt[i] = (i % 2 == 1) ? 8'hFF : 8'h01;
    issue(fill(8'hFE), fill(8'h01), alt);
    wait_done();

    // 4: all -128, sad reaches 8192
    issue(fill(8'h80), fill(8'h80), fill(8'h80));
    wait_done();

    // 5: extra starts at T3 and T9 are ignored; next start one cycle after done is accepted
    a = rnd_vec(100); b = rnd_vec(100); c = rnd_vec(100);
    issue(a, b, c);
    repeat (2) begin @(posedge clk); #1; end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    issue(c, a, b);
    wait_done();

    // 6: reset low at T4, released for T6; block is discarded and outputs clear
    issue(rnd_vec(60), rnd_vec(60), rnd_vec(60));
    repeat (3) begin @(posedge clk); #1; end
    reset = 1'b0;
    @(posedge clk); #1;
    exp_q.delete();
    blk_active = 1'b0;
    last       = zero_exp();
    have_last  = 1'b1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_mode", mode == 2'd0, 512'(mode), 512'(0));
    chk("mid_rst_sad", sad == '0, 512'(sad), 512'(0));
    chk("mid_rst_busy", busy == 1'b0, 512'(busy), 512'(0));
    repeat (12) begin @(posedge clk); #1; end
    issue(fill(8'd1), fill(8'd2), fill(8'd3));
    wait_done();

    // Randomized blocks, some with forced ties between modes
    for (int t = 0; t < 12; t++) begin
      int mag;
      int r;
      mag = (t % 3 == 0) ? 128 : ((t % 3 == 1) ? 20 : 3);
      a = rnd_vec(mag); b = rnd_vec(mag); c = rnd_vec(mag);
      r = $urandom_range(0, 3);
      if (r == 1) b = c;
      if (r == 2) a = b;
      if (r == 3) begin a = c; b = c; end
      issue(a, b, c);
      wait_done();
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
    end

    repeat (3) @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
